// File: rtl/enemy_sprite_sequencer.sv
// rtl/enemy_sprite_sequencer.sv - multi-enemy draw/hold/erase/move sequencer (optional ENEMY_SPRITE_MASK_EN)
module enemy_sprite_sequencer #(
   parameter int NUM_ENEMIES = 4,
   parameter int SPRITE_W    = 4,
   parameter int SPRITE_H    = 4,
   parameter int HOLD_CYCLES = 15,
   parameter int STEP_Y      = 1,
   parameter int Y_BOTTOM    = 110,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int COLOUR_W    = 3
`ifdef ENEMY_SPRITE_MASK_EN
   ,
   parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = '1
`endif
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NUM_ENEMIES-1:0]     enable_mask,
   input  logic [NUM_ENEMIES*X_W-1:0] spawn_x,
   input  logic [COLOUR_W-1:0]        enemy_colour,
   output logic [X_W-1:0]             x_out,
   output logic [Y_W-1:0]             y_out,
   output logic [COLOUR_W-1:0]        colour_out,
   output logic                       plot,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_ENEMIES-1:0]     wrap
);

   localparam int SLOT_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
   localparam int COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [Y_W:0] STEP_EXT = (Y_W+1)'(STEP_Y);
   localparam logic [Y_W:0] YBOT_EXT = (Y_W+1)'(Y_BOTTOM);

   typedef enum logic [2:0] {S_IDLE, S_DRAW, S_HOLD, S_ERASE, S_MOVE, S_DONE} state_t;

   state_t                   state, nx_state;
   logic [SLOT_W-1:0]        slot, nx_slot, first_slot;
   logic [COL_W-1:0]         col, nx_col;
   logic [ROW_W-1:0]         row, nx_row;
   logic [HOLD_W-1:0]        hold_cnt, nx_hold;
   logic [NUM_ENEMIES-1:0]   mask_q, nx_mask;
   logic [COLOUR_W-1:0]      colour_q, nx_colour;
   logic [NUM_ENEMIES-1:0]   spawned, nx_spawned;
   logic [X_W-1:0]           pos_x [NUM_ENEMIES];
   logic [X_W-1:0]           nx_pos_x [NUM_ENEMIES];
   logic [Y_W-1:0]           pos_y [NUM_ENEMIES];
   logic [Y_W-1:0]           nx_pos_y [NUM_ENEMIES];
   logic [Y_W:0]             y_sum [NUM_ENEMIES];
   logic [SLOT_W:0]          hit, first_hit;
   logic [X_W-1:0]           x_d;
   logic [Y_W-1:0]           y_d;
   logic [COLOUR_W-1:0]      colour_d;
   logic                     plot_d;
   logic [NUM_ENEMIES-1:0]   wrap_d;

   // Lowest set bit of m at or above lo; MSB of the result flags "found".
   function automatic logic [SLOT_W:0] find_slot(input logic [NUM_ENEMIES-1:0] m, input int lo);
      find_slot = '0;
      for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
         if (m[i] && (i >= lo)) find_slot = {1'b1, SLOT_W'(i)};
      end
   endfunction

   // Next-row positions at one extra bit so the bottom compare cannot wrap.
   always_comb begin
      for (int i = 0; i < NUM_ENEMIES; i++) y_sum[i] = {1'b0, pos_y[i]} + STEP_EXT;
      first_hit  = find_slot(mask_q, 0);
      first_slot = first_hit[SLOT_W-1:0];
   end

   // Next-state, counters, slot positions and the registered pixel outputs.
   always_comb begin
      nx_state   = state;
      nx_slot    = slot;
      nx_col     = col;
      nx_row     = row;
      nx_hold    = hold_cnt;
      nx_mask    = mask_q;
      nx_colour  = colour_q;
      nx_spawned = spawned;
      nx_pos_x   = pos_x;
      nx_pos_y   = pos_y;
      hit        = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               nx_mask   = enable_mask;
               nx_colour = enemy_colour;
               for (int i = 0; i < NUM_ENEMIES; i++) begin
                  if (enable_mask[i] && !spawned[i]) begin
                     nx_pos_x[i]   = spawn_x[i*X_W +: X_W];
                     nx_pos_y[i]   = '0;
                     nx_spawned[i] = 1'b1;
                  end
               end
               hit = find_slot(enable_mask, 0);
               if (hit[SLOT_W]) begin
                  nx_state = S_DRAW;
                  nx_slot  = hit[SLOT_W-1:0];
                  nx_col   = '0;
                  nx_row   = '0;
               end else begin
                  nx_state = S_DONE;
               end
            end
         end
         S_DRAW, S_ERASE: begin
            if (col != COL_W'(SPRITE_W - 1)) begin
               nx_col = col + 1'b1;
            end else if (row != ROW_W'(SPRITE_H - 1)) begin
               nx_col = '0;
               nx_row = row + 1'b1;
            end else begin
               nx_col = '0;
               nx_row = '0;
               hit    = find_slot(mask_q, int'(slot) + 1);
               if (hit[SLOT_W]) begin
                  nx_slot = hit[SLOT_W-1:0];
               end else if (state == S_ERASE) begin
                  nx_state = S_MOVE;
               end else if (HOLD_CYCLES == 0) begin
                  nx_state = S_ERASE;
                  nx_slot  = first_slot;
               end else begin
                  nx_state = S_HOLD;
                  nx_hold  = '0;
               end
            end
         end
         S_HOLD: begin
            if (int'(hold_cnt) == HOLD_CYCLES - 1) begin
               nx_state = S_ERASE;
               nx_slot  = first_slot;
            end else begin
               nx_hold = hold_cnt + 1'b1;
            end
         end
         S_MOVE: begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
               if (mask_q[i]) begin
                  if (y_sum[i] > YBOT_EXT) nx_spawned[i] = 1'b0;
                  else                     nx_pos_y[i]   = y_sum[i][Y_W-1:0];
               end
            end
            nx_state = S_DONE;
         end
         S_DONE:  nx_state = S_IDLE;
         default: nx_state = S_IDLE;
      endcase

      // Outputs describe the cycle being entered, so they are loaded on the same edge.
      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
      plot_d   = 1'b0;
      if (nx_state == S_DRAW || nx_state == S_ERASE) begin
         x_d      = nx_pos_x[nx_slot] + X_W'(nx_col);
         y_d      = nx_pos_y[nx_slot] + Y_W'(nx_row);
         colour_d = (nx_state == S_DRAW) ? nx_colour : '0;
`ifdef ENEMY_SPRITE_MASK_EN
         plot_d   = SPRITE_MASK[int'(nx_row) * SPRITE_W + int'(nx_col)];
`else
         plot_d   = 1'b1;
`endif
      end
      for (int i = 0; i < NUM_ENEMIES; i++)
         wrap_d[i] = (nx_state == S_MOVE) && mask_q[i] && (y_sum[i] > YBOT_EXT);
   end

   // State, slot table and output registers; reset aborts any frame in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         slot       <= '0;
         col        <= '0;
         row        <= '0;
         hold_cnt   <= '0;
         mask_q     <= '0;
         colour_q   <= '0;
         spawned    <= '0;
         for (int i = 0; i < NUM_ENEMIES; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
         end
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wrap       <= '0;
      end else begin
         state      <= nx_state;
         slot       <= nx_slot;
         col        <= nx_col;
         row        <= nx_row;
         hold_cnt   <= nx_hold;
         mask_q     <= nx_mask;
         colour_q   <= nx_colour;
         spawned    <= nx_spawned;
         pos_x      <= nx_pos_x;
         pos_y      <= nx_pos_y;
         x_out      <= x_d;
         y_out      <= y_d;
         colour_out <= colour_d;
         plot       <= plot_d;
         busy       <= (nx_state != S_IDLE);
         done       <= (nx_state == S_DONE);
         wrap       <= wrap_d;
      end
   end

endmodule

// File: tb/tb_enemy_sprite_sequencer.sv
// tb/tb_enemy_sprite_sequencer.sv - scoreboard bench for enemy_sprite_sequencer
module tb_enemy_sprite_sequencer;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  enable_mask = '0;
   logic [31:0] spawn_x = '0;
   logic [2:0]  enemy_colour = '0;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour_out;
   logic        plot, busy, done;
   logic [3:0]  wrap;

   int   nvec = 0;
   int   nerr = 0;
   pix_t exp_q[$];
   int   mx[4];
   int   my[4];
   bit   msp[4];

   enemy_sprite_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .enable_mask(enable_mask),
      .spawn_x(spawn_x), .enemy_colour(enemy_colour), .x_out(x_out), .y_out(y_out),
      .colour_out(colour_out), .plot(plot), .busy(busy), .done(done), .wrap(wrap)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, x_out, 0);
      chk({tag, "_y"}, y_out, 0);
      chk({tag, "_colour"}, colour_out, 0);
      chk({tag, "_plot"}, plot, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wrap"}, wrap, 0);
   endtask

   task automatic push_pixels(input logic [3:0] m, input logic [2:0] c);
      pix_t p;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            for (int r = 0; r < 4; r++) begin
               for (int q = 0; q < 4; q++) begin
                  p.x = 8'((mx[i] + q) & 8'hFF);
                  p.y = 7'((my[i] + r) & 7'h7F);
                  p.c = c;
                  exp_q.push_back(p);
               end
            end
         end
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic frame(input logic [3:0] m, input logic [2:0] colr, input bit held);
      int k, len, c, p;
      logic [3:0] ew;
      bit seen, ep;
      pix_t e;
      enable_mask  = m;
      enemy_colour = colr;
      start        = 1'b1;
      k  = 0;
      ew = '0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            if (!msp[i]) begin
               mx[i] = int'(spawn_x[i*8 +: 8]);
               my[i] = 0;
               msp[i] = 1'b1;
            end
            k++;
            if (my[i] + 1 > 110) ew[i] = 1'b1;
         end
      end
      push_pixels(m, colr);
      push_pixels(m, 3'd0);
      p   = 16 * k;
      len = (k == 0) ? 1 : 2 * p + 15 + 2;
      @(posedge clock);
      c    = 0;
      seen = 1'b0;
      while (!seen && c < len + 10) begin
         @(negedge clock);
         c++;
         if (held) start = (c < 5) || (c >= p + 3 && c < p + 8);
         else      start = 1'b0;
         ep = (k > 0) && ((c >= 1 && c <= p) || (c > p + 15 && c <= 2 * p + 15));
         chk("plot_timing", plot, ep);
         if (plot) begin
            if (exp_q.size() == 0) begin
               chk("plot_underflow", plot, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", {x_out, y_out, colour_out}, e);
            end
         end
         chk("wrap", wrap, (k > 0 && c == len - 1) ? ew : 4'b0);
         chk("busy", busy, (c <= len) ? 1 : 0);
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
            chk("done_cycle", c, len);
         end
      end
      if (!seen) chk("done_timeout", done, 1);
      chk("queue_left", exp_q.size(), 0);
      exp_q.delete();
      if (k > 0) begin
         for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
               if (my[i] + 1 > 110) msp[i] = 1'b0;
               else                 my[i]  = my[i] + 1;
            end
         end
      end
      repeat (3) begin
         @(negedge clock);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_plot", plot, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         mx[i] = 0; my[i] = 0; msp[i] = 1'b0;
      end
      repeat (3) @(negedge clock);
      chk_all_zero("reset_init");
      reset = 1'b0;
      @(negedge clock);

      // Single slot at x=20, colour 5.
      spawn_x = {8'd0, 8'd50, 8'd0, 8'd20};
      frame(4'b0001, 3'd5, 1'b0);

      // Reset asserted mid-draw clears outputs asynchronously.
      enable_mask  = 4'b0001;
      enemy_colour = 3'd7;
      start        = 1'b1;
      @(posedge clock);
      repeat (10) @(negedge clock);
      start = 1'b0;
      chk("pre_reset_plot", plot, 1);
      #2 reset = 1'b1;
      #1 chk_all_zero("reset_mid");
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) msp[i] = 1'b0;
      @(negedge clock);

      // Two slots with a fresh respawn after reset.
      spawn_x = {8'd0, 8'd50, 8'd0, 8'd10};
      frame(4'b0101, 3'd2, 1'b0);

      // Empty mask.
      frame(4'b0000, 3'd4, 1'b0);

      // Walk slot 0 to the bottom, wrap, then respawn at the new spawn_x.
      spawn_x[7:0] = 8'd30;
      for (int f = 0; f < 111; f++) frame(4'b0001, 3'd3, 1'b0);

      // start held and reasserted during HOLD.
      frame(4'b0101, 3'd6, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/enemy_sprite_sequencer.md
Name: enemy_sprite_sequencer

Overview:
- Parametrised multi-enemy draw/hold/erase/move sequencer for the VGA framebuffer path.
- Per frame, for each enabled enemy slot in turn, it raster-scans a SPRITE_W x SPRITE_H sprite (plot), holds for HOLD_CYCLES, then erases the same pixels in black.
- It then steps every enabled enemy down by STEP_Y and respawns any that pass Y_BOTTOM.
- Sits between the game-tick generator (start) and the VGA adapter (x/y/colour/plot).

Parameters:
- NUM_ENEMIES, 4, number of enemy slots.
- SPRITE_W, 4, sprite width in pixels.
- SPRITE_H, 4, sprite height in pixels.
- HOLD_CYCLES, 15, clock cycles the drawn frame is held before erase.
- STEP_Y, 1, pixels moved down per frame.
- Y_BOTTOM, 110, last legal sprite-origin row; beyond it the enemy respawns.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- enable_mask  in  NUM_ENEMIES  slot enables; latched when start is accepted.
- spawn_x  in  NUM_ENEMIES*X_W  respawn x per slot; slot i occupies bits [i*X_W +: X_W].
- enemy_colour  in  COLOUR_W  draw colour; latched when start is accepted.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- colour_out  out  COLOUR_W  pixel colour; 0 while erasing.
- plot  out  1  pixel write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of frame.
- wrap  out  NUM_ENEMIES  one-cycle pulse per slot that respawned this frame.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - All outputs 0.
  - Per-slot x=0, y=0, spawned=0.
  - Pixel, slot and hold counters 0.
- States: IDLE, DRAW, HOLD, ERASE, MOVE, DONE.
- IDLE:
  - On start=1, latch enable_mask and enemy_colour.
  - Every latched-enabled slot with spawned=0 loads x=spawn_x slice, y=0, spawned=1.
  - Go to DRAW at the lowest enabled slot. If the mask is all-zero, go to DONE instead.
- start while busy=1 is ignored; no queueing.
- DRAW:
  - One pixel per cycle, plot=1, row-major: col 0..SPRITE_W-1 inner, row 0..SPRITE_H-1 outer.
  - x_out=x_slot+col, y_out=y_slot+row; both truncated to X_W/Y_W with no clipping.
  - colour_out=latched colour.
  - After the last pixel of a slot, move to the next-higher enabled slot with no gap cycle. Disabled slots cost zero cycles.
  - After the last enabled slot, go to HOLD.
- HOLD: plot=0 for exactly HOLD_CYCLES cycles, then ERASE. HOLD_CYCLES=0 means ERASE directly.
- ERASE: identical scan order and slot order to DRAW, with colour_out=0 and plot=1. After the last pixel, go to MOVE.
- MOVE: one cycle, plot=0. For each enabled slot:
  - If y+STEP_Y > Y_BOTTOM: spawned=0 and wrap[i]=1 this cycle.
  - Else y <= y+STEP_Y, computed at Y_W+1 bits before the compare.
- DONE: one cycle, done=1, then IDLE.
- Frame length from the accept edge, with K enabled slots and P=SPRITE_W*SPRITE_H: 2*K*P + HOLD_CYCLES + 2 cycles, including MOVE and DONE. All-zero mask: DONE is the first cycle after the accept edge.
- Outputs are registered: x_out, y_out, colour_out and plot change only on clock edges.
- reset asserted mid-frame aborts immediately. No erase is performed; software clears the screen.

Optional Feature:
- Macro ENEMY_SPRITE_MASK_EN.
- When defined:
  - Adds parameter SPRITE_MASK, width SPRITE_W*SPRITE_H, default all-ones. Bit index is row*SPRITE_W+col.
  - In DRAW and ERASE, plot=1 only where the mask bit is 1. The cycle is still consumed, so the frame length is unchanged.
- When undefined: solid rectangle, and plot=1 on every DRAW/ERASE cycle.

Test Plan:
- Reset values: reset high mid-run -> all outputs 0 immediately; state IDLE; next start respawns every enabled slot at spawn_x.
- Single slot: mask=0001, spawn_x[0]=20, colour=5, defaults -> 16 plots covering (20..23, 0..3) in row-major order with colour 5; 15 idle cycles; 16 plots with colour 0; done at cycle 49; y becomes 1.
- Two slots: mask=0101, spawn_x[0]=10, spawn_x[2]=50 -> slot 0 fully drawn, then slot 2 with no gap; 32 DRAW cycles; done at cycle 81.
- Respawn: run 110 frames on slot 0 -> next frame has y=110 drawn; its MOVE pulses wrap[0]; next frame draws at y=0.
- start held high through a frame and reasserted during HOLD -> exactly one done per accepted start; no extra frame starts mid-frame.
- Empty mask: start with mask=0000 -> done one cycle after accept; no plot; positions unchanged.
